encoder_42: RTL and testbench

Registered 4-to-2 binary encoder with priority resolution and input-quality flags. Converts a 4-bit request vector into the 2-bit index of the asserted line, plus `valid` and `multi` status. Sits between one-hot select/request sources and downstream index-consuming logic, giving a clean registered boundary.

---
 rtl/encoder_42.sv | 56 +++++
 tb/tb_encoder_42.sv | 135 +++++++++++++
 2 files changed

// File: rtl/encoder_42.sv
// Registered 4-to-2 priority encoder: the highest-numbered set request line wins.
// It also flags when any line is requested (valid) and when two or more are (multi).
module encoder_42 #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  output logic [1:0] y,
  output logic       valid,
  output logic       multi
);

  logic [1:0] enc_y;
  logic       enc_valid;
  logic       enc_multi;
  logic [2:0] pop_count;

  always_comb begin
    enc_y = 2'd0;
    casez (a)
      4'b1???: enc_y = 2'd3;
      4'b01??: enc_y = 2'd2;
      4'b001?: enc_y = 2'd1;
      default: enc_y = 2'd0;
    endcase
  end

  assign pop_count = {2'b00, a[0]} + {2'b00, a[1]} + {2'b00, a[2]} + {2'b00, a[3]};
  assign enc_valid = |a;
  assign enc_multi = (pop_count >= 3'd2);

  generate
    if (REG_OUT) begin : g_reg
      // All three outputs share one register stage so they always change together.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y     <= 2'd0;
          valid <= 1'b0;
          multi <= 1'b0;
        end else begin
          y     <= enc_y;
          valid <= enc_valid;
          multi <= enc_multi;
        end
      end
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign y     = enc_y;
      assign valid = enc_valid;
      assign multi = enc_multi;
    end
  endgenerate

endmodule

// File: tb/tb_encoder_42.sv
// Directed bench for encoder_42: the registered variant is checked through reset,
// one-hot, zero, priority and async-reset cases; the combinational variant exhaustively.
module tb_encoder_42;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [1:0] y;
  logic       valid;
  logic       multi;

  logic       rst_c;
  logic [3:0] a_c;
  logic [1:0] y_c;
  logic       valid_c;
  logic       multi_c;

  int n_checks = 0;
  int n_errors = 0;

  encoder_42 #(.REG_OUT(1'b1)) dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .y     (y),
    .valid (valid),
    .multi (multi)
  );

  encoder_42 #(.REG_OUT(1'b0)) dut_comb (
    .clk   (clk),
    .rst_n (rst_c),
    .a     (a_c),
    .y     (y_c),
    .valid (valid_c),
    .multi (multi_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model packed as {y, valid, multi}, built from a bit scan and a bit count.
  function automatic logic [3:0] model(input logic [3:0] v);
    logic [1:0] idx;
    int         cnt;
    idx = 2'd0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        idx = 2'(i);
        cnt = cnt + 1;
      end
    end
    return {idx, (cnt > 0), (cnt > 1)};
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got y/valid/multi=%b expected %b", tag, got, exp);
    end
  endtask

  // Drives a vector between edges and checks the registered result just after the next edge.
  task automatic applyStimulus(input string tag, input logic [3:0] vec, input logic [3:0] exp);
    @(negedge clk);
    a = vec;
    @(posedge clk);
    #1;
    checkOutput(tag, {y, valid, multi}, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 4'b1000;
    rst_c = 1'b1;
    a_c   = 4'b0000;

    #1;
    checkOutput("reset_immediate", {y, valid, multi}, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold", {y, valid, multi}, 4'b0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release", {y, valid, multi}, 4'b1110);

    applyStimulus("onehot_0", 4'b0001, 4'b0010);
    applyStimulus("onehot_1", 4'b0010, 4'b0110);
    applyStimulus("onehot_2", 4'b0100, 4'b1010);
    applyStimulus("onehot_3", 4'b1000, 4'b1110);
    applyStimulus("zero",     4'b0000, 4'b0000);

    applyStimulus("prio_0011", 4'b0011, 4'b0111);
    applyStimulus("prio_0110", 4'b0110, 4'b1011);
    applyStimulus("prio_1010", 4'b1010, 4'b1111);
    applyStimulus("prio_1111", 4'b1111, 4'b1111);
    applyStimulus("prio_0101", 4'b0101, 4'b1011);

    applyStimulus("pre_async", 4'b1000, 4'b1110);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_clear", {y, valid, multi}, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("async_hold", {y, valid, multi}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    a     = 4'b0000;
    @(posedge clk);
    #1;
    checkOutput("post_reset_zero", {y, valid, multi}, 4'b0000);

    for (int v = 0; v < 16; v++) begin
      applyStimulus($sformatf("reg_sweep_%0d", v), 4'(v), model(4'(v)));
    end

    for (int v = 0; v < 16; v++) begin
      rst_c = v[0];
      a_c   = 4'(v);
      #1;
      checkOutput($sformatf("comb_sweep_%0d", v), {y_c, valid_c, multi_c}, model(4'(v)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
